// File: rtl/escalonador_quantum.sv
// Round-robin, time-sliced program scheduler: counts retired instructions against a
// quantum and requests context switches, supplying the next program id and base address.
module escalonador_quantum #(
    parameter int NUM_PROGS   = 5,
    parameter int QUANTUM     = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 3,
    parameter int BASE_PROG   = 2000,
    parameter int PROG_STRIDE = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_PROGS-1:0]  prog_enable,
    input  logic                  instr_retired,
    input  logic                  prog_halt,
    output logic                  irq,
    input  logic                  irq_ack,
    input  logic                  ctx_done,
    output logic [ID_WIDTH-1:0]   cur_prog,
    output logic [ID_WIDTH-1:0]   next_prog,
    output logic [ADDR_WIDTH-1:0] next_base,
    output logic                  busy,
    output logic                  all_done
);

    localparam int unsigned      NP    = NUM_PROGS;
    localparam int               CNT_W = $clog2(QUANTUM + 1);
    localparam logic [CNT_W-1:0] QLAST = CNT_W'(QUANTUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_REQ,
        S_SWITCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_PROGS-1:0]  r_active;
    logic [CNT_W-1:0]      r_cnt;
    logic [ID_WIDTH-1:0]   r_cur;
    logic [ID_WIDTH-1:0]   r_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_running;

    logic [NUM_PROGS-1:0]  w_cur_mask;
    logic [NUM_PROGS-1:0]  w_remaining;
    logic [ID_WIDTH-1:0]   w_sel;
    logic [ADDR_WIDTH-1:0] w_sel_base;
    logic                  w_found;
    logic                  w_start_ok;
    logic                  w_halt;
    logic                  w_retire;
    logic                  w_expire;
    logic                  w_direct;

    always_comb begin
        w_cur_mask = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            w_cur_mask[i] = (r_cur == ID_WIDTH'(i));
        end
    end

    assign w_remaining = r_active & ~w_cur_mask;

    // Cyclic search starting after cur_prog (cur_prog last); with nothing running yet,
    // the search base is the last slot so slot 0 is examined first.
    always_comb begin
        int unsigned w_base_idx;
        int unsigned w_pos;
        w_sel      = r_cur;
        w_found    = 1'b0;
        w_base_idx = r_running ? 32'(r_cur) : (NP - 1);
        for (int unsigned k = 1; k <= NP; k++) begin
            w_pos = w_base_idx + k;
            if (w_pos >= NP) begin
                w_pos = w_pos - NP;
            end
            for (int unsigned j = 0; j < NP; j++) begin
                if (!w_found && r_active[j] && (w_pos == j)) begin
                    w_found = 1'b1;
                    w_sel   = ID_WIDTH'(j);
                end
            end
        end
    end

    assign w_sel_base = ADDR_WIDTH'(BASE_PROG)
                      + ADDR_WIDTH'(w_sel) * ADDR_WIDTH'(PROG_STRIDE);

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_halt     = (r_state == S_RUN) && prog_halt;
    assign w_retire   = (r_state == S_RUN) && instr_retired;
    assign w_expire   = w_retire && (r_cnt == QLAST);
    assign w_direct   = r_running && (w_sel == r_cur);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_next_state = (|prog_enable) ? S_PICK : S_DONE;
                end
            end
            S_PICK: begin
                w_next_state = w_direct ? S_RUN : S_REQ;
            end
            S_REQ: begin
                if (irq_ack) begin
                    w_next_state = S_SWITCH;
                end
            end
            S_SWITCH: begin
                if (ctx_done) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                // A halt takes priority over a simultaneous quantum expiry.
                if (w_halt) begin
                    w_next_state = (|w_remaining) ? S_PICK : S_DONE;
                end else if (w_expire) begin
                    w_next_state = S_PICK;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        irq      = (r_state == S_REQ);
        busy     = (r_state == S_PICK) || (r_state == S_REQ)
                || (r_state == S_SWITCH) || (r_state == S_RUN);
        all_done = (r_state == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_active  <= '0;
            r_cnt     <= '0;
            r_cur     <= '0;
            r_next    <= '0;
            r_base    <= '0;
            r_running <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_active  <= prog_enable;
                r_running <= 1'b0;
            end
            if (r_state == S_PICK) begin
                r_next <= w_sel;
                r_base <= w_sel_base;
                if (w_direct) begin
                    r_cnt <= '0;
                end
            end
            if ((r_state == S_SWITCH) && ctx_done) begin
                r_cur     <= r_next;
                r_cnt     <= '0;
                r_running <= 1'b1;
            end
            if (w_halt) begin
                r_active <= w_remaining;
            end else if (w_retire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign cur_prog  = r_cur;
    assign next_prog = r_next;
    assign next_base = r_base;

endmodule

// File: tb/tb_escalonador_quantum.sv
// Self-checking bench for escalonador_quantum: cycle table, directed corner cases,
// and randomized episodes checked against a queue-free round-robin model.
module tb_escalonador_quantum;

    localparam int Q = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  prog_enable;
    logic        instr_retired;
    logic        prog_halt;
    logic        irq;
    logic        irq_ack;
    logic        ctx_done;
    logic [2:0]  cur_prog;
    logic [2:0]  next_prog;
    logic [31:0] next_base;
    logic        busy;
    logic        all_done;

    int n_chk  = 0;
    int n_fail = 0;

    escalonador_quantum #(
        .NUM_PROGS  (5),
        .QUANTUM    (Q),
        .ADDR_WIDTH (32),
        .ID_WIDTH   (3),
        .BASE_PROG  (2000),
        .PROG_STRIDE(1000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .prog_enable  (prog_enable),
        .instr_retired(instr_retired),
        .prog_halt    (prog_halt),
        .irq          (irq),
        .irq_ack      (irq_ack),
        .ctx_done     (ctx_done),
        .cur_prog     (cur_prog),
        .next_prog    (next_prog),
        .next_base    (next_base),
        .busy         (busy),
        .all_done     (all_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       st;
        logic [4:0] en;
        logic       ret, hlt, ack, dn;
        logic       eirq, ebusy, edone;
        int         ecur, enext, ebase;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic [4:0] en, logic ret, logic hlt, logic ack,
                                logic dn, logic eirq, logic ebusy, logic edone,
                                int ecur, int enext, int ebase);
        vec_t v;
        v.st = st; v.en = en; v.ret = ret; v.hlt = hlt; v.ack = ack; v.dn = dn;
        v.eirq = eirq; v.ebusy = ebusy; v.edone = edone;
        v.ecur = ecur; v.enext = enext; v.ebase = ebase;
        return v;
    endfunction

    // Reference round-robin choice: first live slot after c (c itself last); c<0 means none.
    function automatic int model_pick(logic [4:0] alive, int c);
        for (int k = 1; k <= 5; k++) begin
            int s;
            s = (c < 0) ? (k - 1) : ((c + k) % 5);
            if (alive[s]) return s;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        start = 1'b0; instr_retired = 1'b0; prog_halt = 1'b0;
        irq_ack = 1'b0; ctx_done = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic do_reset();
        clr();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic pulse_start(input logic [4:0] m);
        start = 1'b1;
        prog_enable = m;
        tick();
        clr();
    endtask

    task automatic retire(input int n);
        for (int i = 0; i < n; i++) begin
            instr_retired = 1'b1;
            tick();
            clr();
        end
    endtask

    // Entered with the DUT in REQ; optional random delays carry ignored inputs.
    task automatic handshake(input string tag, input int np, input bit rnd);
        int d;
        chk({tag, " irq"}, 32'(irq), 1);
        chk({tag, " next_prog"}, 32'(next_prog), np);
        chk({tag, " next_base"}, next_base, 2000 + 1000 * np);
        d = rnd ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < d; i++) begin
            instr_retired = 1'($urandom_range(0, 1));
            prog_halt     = 1'($urandom_range(0, 1));
            ctx_done      = 1'($urandom_range(0, 1));
            tick();
            clr();
            chk({tag, " irq held"}, 32'(irq), 1);
        end
        irq_ack = 1'b1;
        tick();
        clr();
        chk({tag, " irq after ack"}, 32'(irq), 0);
        d = rnd ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < d; i++) begin
            instr_retired = 1'($urandom_range(0, 1));
            prog_halt     = 1'($urandom_range(0, 1));
            irq_ack       = 1'($urandom_range(0, 1));
            tick();
            clr();
            chk({tag, " irq in switch"}, 32'(irq), 0);
        end
        ctx_done = 1'b1;
        tick();
        clr();
        chk({tag, " cur_prog"}, 32'(cur_prog), np);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] mask;
        logic [4:0] alive;
        int         cur, np, cnt;
        bit         fin, h, rt;

        reset = 1'b0; prog_enable = '0;
        clr();
        tick();
        tick();
        chk("reset irq", 32'(irq), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset all_done", 32'(all_done), 0);
        chk("reset cur", 32'(cur_prog), 0);
        chk("reset next", 32'(next_prog), 0);
        chk("reset base", next_base, 0);
        reset = 1'b1;

        // Mask 00101 walk-through with ignored inputs in IDLE, REQ and SWITCH.
        //             st en       rt h  ak dn  irq bsy dne cur nxt base
        tbl.push_back(mk(0, 5'b00000, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5'b00101, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 1, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 1, 1, 0, 0, 2, 4000));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 1, 0, 0, 1, 0, 0, 2, 4000));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 1, 0, 1, 0, 2, 2, 4000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1, 0, 2, 2, 4000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1, 0, 2, 2, 4000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1, 0, 2, 2, 4000));
        tbl.push_back(mk(0, 5'b00000, 1, 0, 0, 0, 0, 1, 0, 2, 2, 4000));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 1, 1, 0, 2, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 1, 0, 0, 1, 0, 2, 0, 2000));
        tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2000));

        foreach (tbl[i]) begin
            start = tbl[i].st; prog_enable = tbl[i].en;
            instr_retired = tbl[i].ret; prog_halt = tbl[i].hlt;
            irq_ack = tbl[i].ack; ctx_done = tbl[i].dn;
            tick();
            clr();
            chk($sformatf("tbl%0d irq", i), 32'(irq), 32'(tbl[i].eirq));
            chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].ebusy));
            chk($sformatf("tbl%0d all_done", i), 32'(all_done), 32'(tbl[i].edone));
            chk($sformatf("tbl%0d cur", i), 32'(cur_prog), tbl[i].ecur);
            chk($sformatf("tbl%0d next", i), 32'(next_prog), tbl[i].enext);
            chk($sformatf("tbl%0d base", i), next_base, tbl[i].ebase);
        end

        // Single program: expiry reschedules itself without an irq.
        do_reset();
        pulse_start(5'b00010);
        tick();
        handshake("single", 1, 0);
        retire(Q);
        chk("single pick irq", 32'(irq), 0);
        tick();
        chk("single direct irq", 32'(irq), 0);
        chk("single direct busy", 32'(busy), 1);
        chk("single direct cur", 32'(cur_prog), 1);
        chk("single direct next", 32'(next_prog), 1);
        retire(Q - 1);
        chk("single not done yet", 32'(all_done), 0);
        prog_halt = 1'b1;
        tick();
        clr();
        chk("single all_done", 32'(all_done), 1);
        chk("single busy off", 32'(busy), 0);
        chk("single irq off", 32'(irq), 0);

        // Halt coinciding with the quantum-ending retire.
        do_reset();
        pulse_start(5'b00011);
        tick();
        handshake("halt+exp p0", 0, 0);
        retire(Q - 1);
        instr_retired = 1'b1; prog_halt = 1'b1;
        tick();
        clr();
        tick();
        handshake("halt+exp p1", 1, 0);
        retire(Q);
        tick();
        chk("halt+exp no irq", 32'(irq), 0);
        chk("halt+exp next", 32'(next_prog), 1);
        prog_halt = 1'b1;
        tick();
        clr();
        chk("halt+exp all_done", 32'(all_done), 1);

        // Empty mask.
        do_reset();
        pulse_start(5'b00000);
        chk("empty all_done", 32'(all_done), 1);
        chk("empty busy", 32'(busy), 0);
        chk("empty irq", 32'(irq), 0);
        tick();
        chk("empty irq later", 32'(irq), 0);

        // Reset while waiting in SWITCH.
        do_reset();
        pulse_start(5'b00100);
        tick();
        chk("rst-sw irq", 32'(irq), 1);
        chk("rst-sw next", 32'(next_prog), 2);
        irq_ack = 1'b1;
        tick();
        clr();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst-sw irq", 32'(irq), 0);
        chk("rst-sw busy", 32'(busy), 0);
        chk("rst-sw cur", 32'(cur_prog), 0);
        chk("rst-sw next", 32'(next_prog), 0);
        chk("rst-sw base", next_base, 0);
        ctx_done = 1'b1;
        tick();
        clr();
        chk("rst-sw late done busy", 32'(busy), 0);
        chk("rst-sw late done cur", 32'(cur_prog), 0);

        // Randomized episodes against the round-robin model.
        for (int ep = 0; ep < 40; ep++) begin
            mask = (ep % 8 == 7) ? 5'b00000 : 5'($urandom_range(1, 31));
            alive = mask;
            cur = -1;
            fin = 1'b0;
            pulse_start(mask);
            if (mask == 5'b00000) begin
                chk("rnd empty all_done", 32'(all_done), 1);
                chk("rnd empty busy", 32'(busy), 0);
                continue;
            end
            chk("rnd start busy", 32'(busy), 1);
            chk("rnd start irq", 32'(irq), 0);
            for (int slice = 0; slice < 200 && !fin; slice++) begin
                np = model_pick(alive, cur);
                tick();
                if (np != cur) begin
                    handshake("rnd switch", np, 1);
                end else begin
                    chk("rnd keep irq", 32'(irq), 0);
                    chk("rnd keep next", 32'(next_prog), np);
                end
                cur = np;
                cnt = 0;
                for (int c = 0; c < 200; c++) begin
                    h  = ($urandom_range(0, 11) == 0);
                    rt = 1'($urandom_range(0, 1));
                    prog_halt = h;
                    instr_retired = rt;
                    tick();
                    clr();
                    if (h) begin
                        alive[cur] = 1'b0;
                        if (alive == 5'b00000) begin
                            chk("rnd all_done", 32'(all_done), 1);
                            chk("rnd done busy", 32'(busy), 0);
                            chk("rnd done irq", 32'(irq), 0);
                            fin = 1'b1;
                        end
                        break;
                    end
                    if (rt) begin
                        cnt++;
                        if (cnt == Q) break;
                    end
                    chk("rnd run irq", 32'(irq), 0);
                end
                if (!fin) chk("rnd pick irq", 32'(irq), 0);
            end
            chk("rnd episode finished", 32'(fin), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/escalonador_quantum.md
# escalonador_quantum

Round-robin, time-sliced program scheduler for the multiprogrammed processor. It tracks which user programs are still alive and counts retired instructions of the running program against a fixed quantum. On expiry or halt it requests a context switch from the CPU and supplies the next program's id and its base address in the shared instruction memory. Instruction memory layout is fixed: context-switch routine at 0, OS at 1000, program k at 2000 + 1000·k.

## Interface
- NUM_PROGS, 5, number of program slots
- QUANTUM, 64, retired instructions per time slice (≥1)
- ADDR_WIDTH, 32, instruction address width
- ID_WIDTH, 3, program id width (≥ clog2(NUM_PROGS))
- BASE_PROG, 2000, instruction address of program 0
- PROG_STRIDE, 1000, address distance between program slots
- clock  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-low
- start  in  1  OS pulse: begin scheduling
- prog_enable  in  NUM_PROGS  mask of loaded programs, sampled only when start is accepted
- instr_retired  in  1  one pulse per user instruction completed
- prog_halt  in  1  running program executed its halt instruction
- irq  out  1  context-switch request to CPU, held until irq_ack
- irq_ack  in  1  CPU has vectored to the context-switch routine
- ctx_done  in  1  routine finished restoring next_prog
- cur_prog  out  ID_WIDTH  program currently running
- next_prog  out  ID_WIDTH  program to restore
- next_base  out  ADDR_WIDTH  BASE_PROG + next_prog·PROG_STRIDE
- busy  out  1  scheduler active (states PICK, REQ, SWITCH, RUN)
- all_done  out  1  every enabled program has halted

## Operation
- States: IDLE, PICK, REQ, SWITCH, RUN, DONE.
- IDLE/DONE: start=1 → latch active ← prog_enable, clear all_done; active nonzero → PICK (search starts at slot 0, inclusive), else → DONE. start ignored in other states.
- PICK (1 cycle): select first active slot cyclically after cur_prog (cur_prog itself considered last; on first pick from IDLE, slot 0 first). Register next_prog, next_base. If selected == cur_prog and a program is already running → RUN directly, counter cleared, no irq. Else → REQ.
- REQ: irq=1; irq_ack=1 → SWITCH (irq low next cycle).
- SWITCH: wait ctx_done=1 → cur_prog ← next_prog, counter ← 0, → RUN.
- RUN: instr_retired increments counter (width clog2(QUANTUM+1)). Pulse that brings count to QUANTUM → PICK. prog_halt → clear active[cur_prog]; remaining active zero → DONE, else PICK.
- Halt and quantum expiry in same cycle: halt handling wins (bit cleared, same transitions).
- Inputs ignored outside their state: instr_retired/prog_halt outside RUN, irq_ack outside REQ, ctx_done outside SWITCH.
- DONE: all_done=1, busy=0, irq=0; outputs hold last values.
- next_base computed with ADDR_WIDTH arithmetic; no wrap check (parameters must fit).

## Timing
- Reset (reset=0 at a posedge): state IDLE, irq=0, cur_prog=0, next_prog=0, next_base=0, busy=0, all_done=0, active=0, counter=0. Applies mid-operation, incl. REQ/SWITCH; later ack/done ignored.
- start sampled at edge t → PICK at t+1 → irq=1 from t+2 with next_prog/next_base already valid.
- Quantum-ending instr_retired at edge t → irq=1 from t+2.
- irq_ack at edge t → irq=0 from t+1. ctx_done at edge t → cur_prog updated and RUN from t+1; instr_retired counted from edge t+1 on.
- next_prog/next_base stable from PICK until next PICK.
- Last halt at edge t → all_done=1, busy=0 from t+1.

## Test plan
- QUANTUM=4, mask 00101: start, ack, done → cur_prog=0; 4 retires → irq, next_prog=2, next_base=4000; ack/done; 4 retires → next_prog=0, next_base=2000.
- Mask 00010: first switch next_base=3000; 4 retires → no irq, counter reset, cur_prog stays 1; halt → all_done=1 one cycle later, irq never re-asserted.
- Mask 00011, on prog 0 assert halt and 4th retire together → next_prog=1; prog 0 never selected again; halt prog 1 → all_done=1.
- start with mask 00000 → DONE at next edge, all_done=1, irq=0 throughout.
- reset=0 during SWITCH → next edge irq=0, busy=0, cur_prog=0; subsequent ctx_done ignored.
- Spurious irq_ack/ctx_done in IDLE and instr_retired in REQ/SWITCH → no state change, retirements not counted (quantum still needs 4 retires in RUN).
